// File: rtl/and2b_if.sv
// Operand/enable inputs and registered result plus power-phase status of one
// two-stage adiabatic AND gate; master drives operands, slave is the gate.
interface and2b_if;
    logic       en;
    logic       a;
    logic       b;
    logic       out;
    logic       out_n;
    logic       out_valid;
    logic [1:0] pc_on;
    logic [2:0] phase;

    modport master (
        output en, a, b,
        input  out, out_n, out_valid, pc_on, phase
    );

    modport slave (
        input  en, a, b,
        output out, out_n, out_valid, pc_on, phase
    );
endinterface

// File: rtl/and2b.sv
// Two-stage adiabatic AND gate: stage 1 samples a&b, stage 2 buffers it; a
// sequencer walks IDLE->S1->S12->HOLD->S1D, STEP_CYCLES clocks per state.
module and2b #(
    parameter int STEP_CYCLES = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    and2b_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S12  = 3'd2,
        HOLD = 3'd3,
        S1D  = 3'd4
    } phase_e;

    localparam int            CW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    phase_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          n1_q,    n1_d;
    logic          n2_q,    n2_d;
    logic          out_q,   out_d;
    logic          out_n_q, out_n_d;
    logic          vld_q,   vld_d;
    logic [1:0]    pc_q,    pc_d;
    logic          last_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n1_q    <= 1'b0;
            n2_q    <= 1'b0;
            out_q   <= 1'b0;
            out_n_q <= 1'b0;
            vld_q   <= 1'b0;
            pc_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            out_q   <= out_d;
            out_n_q <= out_n_d;
            vld_q   <= vld_d;
            pc_q    <= pc_d;
        end
    end

    // The step counter free-runs and wraps every STEP_CYCLES clocks, so IDLE
    // also dwells in whole steps and a start is only taken on its last clock.
    always_comb begin
        state_d   = state_q;
        n1_d      = n1_q;
        n2_d      = n2_q;
        out_d     = out_q;
        out_n_d   = out_n_q;
        vld_d     = vld_q;
        pc_d      = pc_q;
        last_step = (cnt_q == LAST);
        cnt_d     = last_step ? '0 : cnt_q + 1'b1;

        if (last_step) begin
            case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        state_d = S1;
                        n1_d    = bus.a & bus.b;
                        pc_d    = 2'b01;
                    end
                end
                S1: begin
                    state_d = S12;
                    n2_d    = n1_q;
                    pc_d    = 2'b11;
                    out_d   = n1_q;
                    out_n_d = ~n1_q;
                    vld_d   = 1'b1;
                end
                S12: begin
                    state_d = HOLD;
                end
                HOLD: begin
                    state_d = S1D;
                    pc_d    = 2'b01;
                    n2_d    = 1'b0;
                    out_d   = 1'b0;
                    out_n_d = 1'b0;
                    vld_d   = 1'b0;
                end
                S1D: begin
                    state_d = IDLE;
                    pc_d    = 2'b00;
                    n1_d    = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    pc_d    = 2'b00;
                    n1_d    = 1'b0;
                    n2_d    = 1'b0;
                    out_d   = 1'b0;
                    out_n_d = 1'b0;
                    vld_d   = 1'b0;
                end
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_n     = out_n_q;
    assign bus.out_valid = vld_q;
    assign bus.pc_on     = pc_q;
    assign bus.phase     = state_q;

endmodule

// File: tb/tb_and2b.sv
// Drives an and2b with STEP_CYCLES=1 and one with STEP_CYCLES=3 through directed
// and random traffic, comparing every cycle against a timing-level model.
module tb_and2b;

    logic clk = 1'b0;
    logic rst1_n, rst3_n;
    always #5 clk = ~clk;

    and2b_if if1 ();
    and2b_if if3 ();

    and2b #(.STEP_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(if1.slave));
    and2b #(.STEP_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(if3.slave));

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: a cycle is "age" clocks old; each of the four active states spans
    // STEP clocks, and IDLE dwell is counted so starts land on step boundaries.
    int st[2]   = '{1, 3};
    bit busy[2] = '{0, 0};
    int age[2]  = '{0, 0};
    int iage[2] = '{0, 0};
    bit v[2]    = '{0, 0};

    task automatic mdl_upd(input int i, input bit rst_n, input bit en, input bit a, input bit b);
        if (!rst_n) begin
            busy[i] = 0; iage[i] = 0; v[i] = 0; age[i] = 0;
        end else if (busy[i]) begin
            age[i]++;
            if (age[i] == 4 * st[i]) begin
                busy[i] = 0; iage[i] = 0;
            end
        end else if (en && (iage[i] % st[i] == st[i] - 1)) begin
            busy[i] = 1; age[i] = 0; v[i] = a & b;
        end else begin
            iage[i]++;
        end
    endtask

    function automatic int exp_phase(input int i);
        return busy[i] ? 1 + age[i] / st[i] : 0;
    endfunction

    task automatic mdl_cmp(input int i, input logic [2:0] ph, input logic [1:0] pc,
                           input logic o, input logic on, input logic vl);
        int p;
        bit act;
        p   = exp_phase(i);
        act = (p == 2) || (p == 3);
        chk($sformatf("d%0d_phase", i), 8'(ph), 8'(p));
        chk($sformatf("d%0d_pc_on", i), 8'(pc), (p == 0) ? 8'd0 : (act ? 8'd3 : 8'd1));
        chk($sformatf("d%0d_out", i), 8'(o), 8'(act && v[i]));
        chk($sformatf("d%0d_out_n", i), 8'(on), 8'(act && !v[i]));
        chk($sformatf("d%0d_out_valid", i), 8'(vl), 8'(act));
    endtask

    always @(posedge clk) begin
        mdl_upd(0, rst1_n, if1.en, if1.a, if1.b);
        mdl_upd(1, rst3_n, if3.en, if3.a, if3.b);
    end

    always @(negedge clk) begin
        if (mon_on) begin
            mdl_cmp(0, if1.phase, if1.pc_on, if1.out, if1.out_n, if1.out_valid);
            mdl_cmp(1, if3.phase, if3.pc_on, if3.out, if3.out_n, if3.out_valid);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int pct[6] = '{0, 1, 3, 3, 1, 0};
        int pht[6] = '{0, 1, 2, 3, 4, 0};
        int k;

        rst1_n = 1'b0; rst3_n = 1'b0;
        if1.en = 1'b0; if1.a = 1'b0; if1.b = 1'b0;
        if3.en = 1'b0; if3.a = 1'b0; if3.b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mon_on = 1'b1;
        cyc(1);

        // reset state
        chk("t1_phase", 8'(if1.phase), 8'd0);
        chk("t1_pc_on", 8'(if1.pc_on), 8'd0);
        chk("t1_out", 8'(if1.out), 8'd0);
        chk("t1_out_n", 8'(if1.out_n), 8'd0);
        chk("t1_valid", 8'(if1.out_valid), 8'd0);
        chk("t1_phase3", 8'(if3.phase), 8'd0);
        rst1_n = 1'b1; rst3_n = 1'b1;

        // truth table
        for (int p = 0; p < 4; p++) begin
            if1.a = p[1]; if1.b = p[0]; if1.en = 1'b1;
            cyc(2);
            chk("t2_phase", 8'(if1.phase), 8'd2);
            chk("t2_out", 8'(if1.out), (p == 3) ? 8'd1 : 8'd0);
            chk("t2_out_n", 8'(if1.out_n), (p == 3) ? 8'd0 : 8'd1);
            cyc(3);
        end

        // phase order
        if1.a = 1'b1; if1.b = 1'b1;
        for (int s = 0; s < 6; s++) begin
            chk("t3_pc_on", 8'(if1.pc_on), 8'(pct[s]));
            chk("t3_phase", 8'(if1.phase), 8'(pht[s]));
            chk("t3_out", 8'(if1.out), (pht[s] == 2 || pht[s] == 3) ? 8'd1 : 8'd0);
            if (s < 5) cyc(1);
        end

        // input isolation
        cyc(1);
        if1.a = 1'b0;
        cyc(1);
        chk("t4_out_s12", 8'(if1.out), 8'd1);
        cyc(1);
        chk("t4_out_hold", 8'(if1.out), 8'd1);
        cyc(2);

        // enable control
        if1.a = 1'b1;
        cyc(2);
        if1.en = 1'b0;
        cyc(6);
        chk("t5_idle", 8'(if1.phase), 8'd0);
        if1.en = 1'b1;
        cyc(1);
        chk("t5_restart", 8'(if1.phase), 8'd1);
        cyc(4);

        // reset mid-HOLD
        cyc(3);
        chk("t6_hold_out", 8'(if1.out), 8'd1);
        rst1_n = 1'b0;
        cyc(1);
        chk("t6_out", 8'(if1.out), 8'd0);
        chk("t6_valid", 8'(if1.out_valid), 8'd0);
        chk("t6_pc_on", 8'(if1.pc_on), 8'd0);
        chk("t6_phase", 8'(if1.phase), 8'd0);
        rst1_n = 1'b1;

        // STEP_CYCLES=3: each phase lasts 3 clocks
        if3.a = 1'b1; if3.b = 1'b1; if3.en = 1'b1;
        k = 0;
        while (k < 10 && if3.phase == 3'd0) begin
            cyc(1);
            k++;
        end
        for (int s = 0; s < 12; s++) begin
            chk("t6b_phase", 8'(if3.phase), 8'(1 + s / 3));
            cyc(1);
        end
        chk("t6b_idle", 8'(if3.phase), 8'd0);

        // random traffic on both gates
        for (int c = 0; c < 3000; c++) begin
            rst1_n = ($urandom_range(0, 59) != 0);
            rst3_n = ($urandom_range(0, 99) != 0);
            if1.en = ($urandom_range(0, 3) != 0);
            if3.en = ($urandom_range(0, 3) != 0);
            if1.a  = 1'($urandom); if1.b = 1'($urandom);
            if3.a  = 1'($urandom); if3.b = 1'($urandom);
            cyc(1);
        end

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
